// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and sizing for the register-file write-port arbiter.
// Every arbiter file imports this package.
package rf_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 3;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] rf_addr_t;
  typedef logic [DATA_WIDTH-1:0] rf_data_t;

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } rr_state_t;

  // Returns a one-hot register mask, with one bit set for the given address.
  function automatic logic [NUM_REGS-1:0] addr_onehot(input rf_addr_t addr);
    logic [NUM_REGS-1:0] mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Groups the two requester handshakes, the hold control and the register-file
// write port into one bundle.
interface rf_write_arbiter_if
  import rf_pkg::*;
  ();

  logic                req0_valid;
  rf_addr_t            req0_addr;
  rf_data_t            req0_data;
  logic                req0_ready;
  logic                req1_valid;
  rf_addr_t            req1_addr;
  rf_data_t            req1_data;
  logic                req1_ready;
  logic                hold;
  logic                rf_reg_write;
  rf_addr_t            rf_write_reg;
  rf_data_t            rf_write_data;
  logic [NUM_REGS-1:0] pending;

  // The master side holds the requesters and the hold source.
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output hold,
    input  req0_ready, req1_ready,
    input  rf_reg_write, rf_write_reg, rf_write_data, pending
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  hold,
    output req0_ready, req1_ready,
    output rf_reg_write, rf_write_reg, rf_write_data, pending
  );

endinterface

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. The single rr_last flop records the last winner.
// When both requesters are valid, the grant goes to the other one.
module rr_arb2
  import rf_pkg::*;
  (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       advance,
  input  logic       hold,
  output logic [1:0] grant
);

  rr_state_t rr_last_q, rr_last_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last_q <= LAST1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

  // Grants are suppressed while reset is asserted, so ready never leaks out during reset.
  always_comb begin
    grant     = 2'b00;
    rr_last_d = rr_last_q;
    if (!reset && !hold) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (rr_last_q == LAST1) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
    if (advance && (grant != 2'b00)) begin
      rr_last_d = grant[1] ? LAST1 : LAST0;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between two valid/ready requesters.
// The port is driven from a registered stage, one cycle after acceptance.
module rf_write_arbiter
  import rf_pkg::*;
  (
  input  logic                clk,
  input  logic                reset,
  rf_write_arbiter_if.slave   bus
);

  logic [1:0] valid;
  logic [1:0] grant;
  logic       advance;

  logic                reg_write_q, reg_write_d;
  rf_addr_t            write_reg_q, write_reg_d;
  rf_data_t            write_data_q, write_data_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;

  assign valid   = {bus.req1_valid, bus.req0_valid};
  assign advance = |grant;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .valid   (valid),
    .advance (advance),
    .hold    (bus.hold),
    .grant   (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  // Address and data keep their last values when idle. Only a granted requester's
  // fields are captured, so data on an invalid requester never reaches the port.
  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    pending_d    = '0;
    if (grant[0]) begin
      reg_write_d  = 1'b1;
      write_reg_d  = bus.req0_addr;
      write_data_d = bus.req0_data;
    end else if (grant[1]) begin
      reg_write_d  = 1'b1;
      write_reg_d  = bus.req1_addr;
      write_data_d = bus.req1_data;
    end
    if (reg_write_d) begin
      pending_d = addr_onehot(write_reg_d);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      pending_q    <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      pending_q    <= pending_d;
    end
  end

  assign bus.rf_reg_write  = reg_write_q;
  assign bus.rf_write_reg  = write_reg_q;
  assign bus.rf_write_data = write_data_q;
  assign bus.pending       = pending_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter. Expected writes go into a queue at each
// accepting edge, and a negedge monitor compares them against the write port.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  typedef struct {
    rf_addr_t addr;
    rf_data_t data;
  } exp_t;

  logic clk;
  logic reset;
  int   totalCount;
  int   badCount;
  exp_t expQ[$];
  rf_addr_t lastAddr;
  rf_data_t lastData;
  rf_data_t tbRegs [NUM_REGS];

  rf_write_arbiter_if ifc ();

  rf_write_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  // The free-running clock has a period of 10, with rising edges at 5, 15, 25 and so on.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one value and records the result in the shared counters.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    totalCount++;
    if (act !== want) begin
      badCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Call this one time unit after a rising edge. It drives one cycle of inputs and checks ready before the next edge.
  // At that edge, it queues the write that the hand-computed grant says is accepted.
  task automatic applyStimulus(input logic v0, input rf_addr_t a0, input rf_data_t d0,
                               input logic v1, input rf_addr_t a1, input rf_data_t d1,
                               input logic h, input logic e0, input logic e1);
    exp_t e;
    ifc.req0_valid = v0;
    ifc.req0_addr  = a0;
    ifc.req0_data  = d0;
    ifc.req1_valid = v1;
    ifc.req1_addr  = a1;
    ifc.req1_data  = d1;
    ifc.hold       = h;
    #3;
    checkOutput("req0_ready", {31'd0, ifc.req0_ready}, {31'd0, e0});
    checkOutput("req1_ready", {31'd0, ifc.req1_ready}, {31'd0, e1});
    @(posedge clk);
    if (e0) begin
      e.addr = a0;
      e.data = d0;
      expQ.push_back(e);
    end
    if (e1) begin
      e.addr = a1;
      e.data = d1;
      expQ.push_back(e);
    end
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Checks the write port against the queue after each rising edge. An empty queue means the port must be idle and holding.
  always @(negedge clk) begin
    exp_t e;
    checkOutput("one_ready", {31'd0, ifc.req0_ready & ifc.req1_ready}, 32'd0);
    if (reset) begin
      checkOutput("rst_reg_write", {31'd0, ifc.rf_reg_write}, 32'd0);
    end else if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("reg_write", {31'd0, ifc.rf_reg_write}, 32'd1);
      checkOutput("write_reg", {29'd0, ifc.rf_write_reg}, {29'd0, e.addr});
      checkOutput("write_data", ifc.rf_write_data, e.data);
      checkOutput("pending", {24'd0, ifc.pending}, {24'd0, addr_onehot(e.addr)});
      lastAddr = e.addr;
      lastData = e.data;
    end else begin
      checkOutput("idle_reg_write", {31'd0, ifc.rf_reg_write}, 32'd0);
      checkOutput("idle_pending", {24'd0, ifc.pending}, 32'd0);
      checkOutput("idle_write_reg", {29'd0, ifc.rf_write_reg}, {29'd0, lastAddr});
      checkOutput("idle_write_data", ifc.rf_write_data, lastData);
    end
    if (!reset && ifc.rf_reg_write === 1'b1) begin
      tbRegs[ifc.rf_write_reg] = ifc.rf_write_data;
    end
  end

  // Stops the run if the directed sequence somehow overruns its time budget.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    totalCount = 0;
    badCount   = 0;
    lastAddr   = '0;
    lastData   = '0;
    for (int i = 0; i < NUM_REGS; i++) tbRegs[i] = '0;
    reset          = 1'b1;
    ifc.req0_valid = 1'b1;
    ifc.req0_addr  = 3'd1;
    ifc.req0_data  = 32'hFFFF_FFFF;
    ifc.req1_valid = 1'b0;
    ifc.req1_addr  = '0;
    ifc.req1_data  = '0;
    ifc.hold       = 1'b0;

    #2;
    checkOutput("reset_reg_write", {31'd0, ifc.rf_reg_write}, 32'd0);
    checkOutput("reset_write_reg", {29'd0, ifc.rf_write_reg}, 32'd0);
    checkOutput("reset_write_data", ifc.rf_write_data, 32'd0);
    checkOutput("reset_pending", {24'd0, ifc.pending}, 32'd0);
    checkOutput("reset_ready0", {31'd0, ifc.req0_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single write from req0. The register model should then show register 2 written.
    applyStimulus(1'b1, 3'd2, 32'h5555_5555, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    idleCycle();

    // req1 issues three back-to-back writes. pending should walk 0x02, 0x40, 0x80.
    applyStimulus(1'b0, '0, '0, 1'b1, 3'd1, 32'h0101_0101, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 3'd6, 32'h0606_0606, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 3'd7, 32'h0707_0707, 1'b0, 1'b0, 1'b1);
    idleCycle();

    // Contention with rr_last at LAST1: req0 wins first, then the grants alternate.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 3'd3, 32'h1111_1111, 1'b1, 3'd4, 32'h2222_2222, 1'b0,
                    (i % 2 == 0), (i % 2 == 1));
    end

    // Hold test. The last grant was req1, so req0 wins next, then hold freezes acceptance.
    // On release, req1 wins, because it is opposite the preserved rr_last.
    applyStimulus(1'b1, 3'd3, 32'h3333_3333, 1'b1, 3'd4, 32'h4444_4444, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3'd3, 32'h3333_3333, 1'b1, 3'd4, 32'h4444_4444, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 3'd3, 32'h3333_3333, 1'b1, 3'd4, 32'h4444_4444, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'd3, 32'h3333_3333, 1'b1, 3'd4, 32'h4444_4444, 1'b0, 1'b1, 1'b0);
    idleCycle();

    // Reset mid-transfer. The in-flight write to register 2 must vanish without waiting for a clock.
    applyStimulus(1'b1, 3'd2, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("midrst_reg_write", {31'd0, ifc.rf_reg_write}, 32'd0);
    checkOutput("midrst_pending", {24'd0, ifc.pending}, 32'd0);
    checkOutput("midrst_ready0", {31'd0, ifc.req0_ready}, 32'd0);
    expQ.delete();
    lastAddr = '0;
    lastData = '0;
    #5;
    reset          = 1'b0;
    ifc.req0_valid = 1'b0;
    @(posedge clk);
    #1;

    // Collision on register 5. req0 wins first after reset, so req1's data ends up in the register.
    applyStimulus(1'b1, 3'd5, 32'hAAAA_AAAA, 1'b1, 3'd5, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 3'd5, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    idleCycle();
    idleCycle();

    checkOutput("queue_drained", expQ.size(), 32'd0);
    checkOutput("reg1", tbRegs[1], 32'h0101_0101);
    checkOutput("reg2", tbRegs[2], 32'h5555_5555);
    checkOutput("reg3", tbRegs[3], 32'h3333_3333);
    checkOutput("reg4", tbRegs[4], 32'h4444_4444);
    checkOutput("reg5", tbRegs[5], 32'h1234_5678);
    checkOutput("reg6", tbRegs[6], 32'h0606_0606);
    checkOutput("reg7", tbRegs[7], 32'h0707_0707);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (write_reg, write_data, reg_write) between two writeback requesters, e.g. ALU result and memory load.
- Uses a valid/ready handshake on each requester and round-robin arbitration.
- Drives the write port from a registered output stage, so the port sees clean, glitch-free controls one cycle after acceptance.
- Sits between the execute/memory stages and the 8 x 32-bit register file.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 3, register address width; register count is 2**ADDR_WIDTH = 8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  ADDR_WIDTH  destination register for requester 0.
- req0_data  in  DATA_WIDTH  write data for requester 0.
- req0_ready  out  1  requester 0 write is accepted this cycle.
- req1_valid  in  1  requester 1 has a write pending.
- req1_addr  in  ADDR_WIDTH  destination register for requester 1.
- req1_data  in  DATA_WIDTH  write data for requester 1.
- req1_ready  out  1  requester 1 write is accepted this cycle.
- hold  in  1  freezes acceptance, e.g. during a register dump.
- rf_reg_write  out  1  to register file reg_write.
- rf_write_reg  out  ADDR_WIDTH  to register file write_reg.
- rf_write_data  out  DATA_WIDTH  to register file write_data.
- pending  out  2**ADDR_WIDTH  one-hot of the register with a write in flight; all zero otherwise.

Behaviour:
- Reset is asynchronous: rf_reg_write=0, rf_write_reg=0, rf_write_data=0, pending=0, rr_last=1 (so req0 wins first).
- reqN_ready is combinational: 0 whenever reset=1 or hold=1.
- A transfer occurs when reqN_valid and reqN_ready are both 1 at a rising edge. The requester may change addr/data only after a transfer.
- Arbitration, evaluated every cycle with hold=0:
  - Neither valid: no grant.
  - Exactly one valid: grant it.
  - Both valid: grant the requester opposite rr_last.
- Round-robin state is one flop, rr_last, which equals the last granted requester. It is two-state (LAST0/LAST1), updated only on a transfer and unchanged on idle or hold cycles.
- Latency: a transfer at edge N gives rf_reg_write=1 with the captured addr/data from edge N to edge N+1. The register file commits at edge N+1.
- If no transfer occurs at edge N, rf_reg_write=0 after edge N. rf_write_reg and rf_write_data hold their last values, with no toggling when idle.
- Throughput is 1 write per cycle. Each requester waits at most 1 cycle while the other is also valid and hold=0.
- pending = one-hot(rf_write_reg) when rf_reg_write=1, else 0; it is registered alongside the output stage.
- Same-address collision: the two writes are serialised in grant order, so the later grant's data is the final register content. No merging.
- hold=1: no new transfers. A write already in the output stage still commits, and rf_reg_write is 0 on the following cycle. On release, arbitration resumes from the preserved rr_last.
- Reset asserted mid-operation: the output stage is cleared immediately (asynchronously) and any in-flight write is dropped. Requesters must re-present their writes after reset.
- Never issue ready to both requesters in the same cycle.
- No X on outputs after reset, regardless of input X on data when valid=0.

Decomposition:
- Shared package rf_pkg holds:
  - constants DATA_WIDTH=32, ADDR_WIDTH=3, NUM_REGS=8;
  - typedef rf_addr_t (ADDR_WIDTH bits), rf_data_t (DATA_WIDTH bits);
  - enum rr_state_t {LAST0, LAST1}.
- One sub-module, rr_arb2, contains the rr_last flop and the grant logic. Its interface is valid[1:0], advance, hold, and grant[1:0] one-hot.
- The top level contains the output stage and pending logic.

Test Plan:
- Reset: assert reset mid-transfer with req0_valid=1 -> rf_reg_write, pending and req0_ready go to 0 immediately without waiting for a clock. After release, req0 is granted first.
- Single write: req0 valid, addr=2, data=0x55555555 -> req0_ready=1 that cycle; next cycle rf_reg_write=1, rf_write_reg=2, pending=8'b00000100. Register 2 reads 0x55555555 after the following edge.
- Contention: req0 valid (addr=3, data=0x11111111) and req1 valid (addr=4, data=0x22222222), held continuously with 4 writes each -> grants alternate 0,1,0,1,...; rf_reg_write stays 1 every cycle; never both ready.
- Hold: both valid, then hold=1 for 3 cycles -> both ready=0 and rf_reg_write=0 after the in-flight write. On release, the requester opposite rr_last is granted first.
- Collision: both write addr=5, req0 data=0xAAAAAAAA, req1 data=0x12345678, from reset -> req0 commits first, req1 next. Register 5 ends at 0x12345678.
- Back-to-back: req1 alone issues 3 consecutive writes to regs 1, 6, 7 -> ready=1 on 3 consecutive cycles; rf_write_reg sequence is 1, 6, 7 on consecutive cycles; pending walks 0x02, 0x40, 0x80.
